// File: rtl/handshake_rx_fifo.sv
// Destination-side endpoint of a 4-phase req/ack transfer: synchronizes req, buffers words in a
// small FIFO and streams them out as valid/ready. Define HANDSHAKE_RX_STATS_EN for counters.
module handshake_rx_fifo #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_async,
    input  logic [WIDTH-1:0]         data_async,
    output logic                     ack,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef HANDSHAKE_RX_STATS_EN
    output logic [31:0]              word_count,
    output logic [31:0]              stall_count,
`endif
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        StIdle,
        StAcked
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_s;

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   wr_en, rd_en, full, stall;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [LVL_W-1:0]       stored;
    logic                   m_valid_q, m_valid_d;
    logic [WIDTH-1:0]       m_data_q, m_data_d;

    // Plain flop chain: nothing may sit between the stages.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign full  = (level_q == LVL_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_s) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = StAcked;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            StAcked: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Output stage lags the FIFO by one edge; only entries stored before this edge can be
    // presented, so a word written now becomes visible on the following edge.
    always_comb begin
        rd_en     = m_valid_q & m_ready;
        level_d   = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
        stored    = level_q - LVL_W'(rd_en);
        m_valid_d = (stored != '0);
        m_data_d  = m_valid_d ? mem_q[rd_ptr_d] : m_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            ack_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            ack_q     <= ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_async;
        end
    end

    assign ack        = ack_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign fifo_level = level_q;

`ifdef HANDSHAKE_RX_STATS_EN
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        word_count_d  = word_count_q + 32'(wr_en);
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Scoreboard bench for handshake_rx_fifo: stimulus pushes expected words, a negedge monitor
// pops and compares every accepted stream beat. Stats checks compile in with HANDSHAKE_RX_STATS_EN.
module tb_handshake_rx_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_async;
    logic [31:0] data_async;
    logic        ack;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fifo_level;
`ifdef HANDSHAKE_RX_STATS_EN
    logic [31:0] word_count;
    logic [31:0] stall_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          max_level;

    handshake_rx_fifo #(
        .WIDTH      (32),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef HANDSHAKE_RX_STATS_EN
        .word_count (word_count),
        .stall_count(stall_count),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input int max, input string name);
        int n = 0;
        while (ack !== v && n < max) begin
            tick();
            n++;
        end
        check(name, ack, v);
    endtask

    task automatic xfer(input logic [31:0] d);
        data_async = d;
        req_async  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, 20, "xfer_ack_rise");
        req_async = 1'b0;
        wait_ack(1'b0, 20, "xfer_ack_fall");
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check(name, exp_q.size(), 0);
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        exp_q.delete();
        resetn = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: a beat is accepted at the next rising edge.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (m_valid && m_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_unexpected: got %0h, expected no beat", m_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        n_fail++;
                        $display("FAIL stream_data: got %0h, expected %0h", m_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn     = 1'b0;
        req_async  = 1'b0;
        data_async = '0;
        m_ready    = 1'b0;
        max_level  = 0;
        tick();
        tick();
        check("reset_ack", ack, 1'b0);
        check("reset_valid", m_valid, 1'b0);
        check("reset_level", fifo_level, 3'd0);
        check("reset_data", m_data, 32'h0);
        resetn = 1'b1;
        tick();

        // 1: single transfer with exact edge timing
        data_async = 32'hDEAD_BEEF;
        req_async  = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        tick();
        check("s1_ack_edge2", ack, 1'b0);
        tick();
        check("s1_ack_edge3", ack, 1'b1);
        check("s1_level_edge3", fifo_level, 3'd1);
        check("s1_valid_edge3", m_valid, 1'b0);
        tick();
        check("s1_valid_edge4", m_valid, 1'b1);
        check("s1_data_edge4", m_data, 32'hDEAD_BEEF);
        req_async = 1'b0;
        tick();
        tick();
        check("s1_ack_hold", ack, 1'b1);
        tick();
        check("s1_ack_fall", ack, 1'b0);
        drain("s1_drain");

        // 2: fill to full, fifth request stalls until one pop
        do_reset();
        for (int i = 1; i <= 4; i++) xfer(32'(i));
        check("s2_level_full", fifo_level, 3'd4);
        check("s2_head", m_data, 32'h1);
        data_async = 32'h5;
        req_async  = 1'b1;
        exp_q.push_back(32'h5);
        // req_s is seen from edge 3 onward: edges 3..10 stall (8)
        for (int i = 0; i < 10; i++) tick();
        check("s2_no_ack_full", ack, 1'b0);
        m_ready = 1'b1;
        tick();
        // read on this edge does not unblock the write in the same cycle (stall 9)
        m_ready = 1'b0;
        check("s2_blocked_same_cycle", ack, 1'b0);
        check("s2_level_after_pop", fifo_level, 3'd3);
        tick();
        check("s2_fifth_ack", ack, 1'b1);
        check("s2_level_refill", fifo_level, 3'd4);
`ifdef HANDSHAKE_RX_STATS_EN
        check("s6_word_count", word_count, 32'd5);
        check("s6_stall_count", stall_count, 32'd9);
`endif
        req_async = 1'b0;
        wait_ack(1'b0, 20, "s2_ack_fall");
        drain("s2_drain");
        check("s2_empty_level", fifo_level, 3'd0);
        check("s2_empty_valid", m_valid, 1'b0);

        // 3: streaming with consumer always ready
        m_ready   = 1'b1;
        max_level = 0;
        for (int i = 0; i < 16; i++) xfer(32'(i));
        drain("s3_drain");
        check("s3_max_level", 32'(max_level), 32'd1);

        // 4: reset in the middle of a transfer with req still high
        m_ready = 1'b0;
        xfer(32'h11);
        data_async = 32'h22;
        req_async  = 1'b1;
        exp_q.push_back(32'h22);
        wait_ack(1'b1, 20, "s4_ack_second");
        check("s4_level2", fifo_level, 3'd2);
        resetn = 1'b0;
        #1;
        check("s4_rst_ack", ack, 1'b0);
        check("s4_rst_valid", m_valid, 1'b0);
        check("s4_rst_level", fifo_level, 3'd0);
        exp_q.delete();
        exp_q.push_back(32'h22);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("s4_ack_sync", ack, 1'b0);
        tick();
        check("s4_recapture_ack", ack, 1'b1);
        check("s4_recapture_level", fifo_level, 3'd1);
        req_async = 1'b0;
        wait_ack(1'b0, 20, "s4_ack_fall");
        drain("s4_drain");

        // 5: only the value present at the capture edge is stored
        data_async = 32'hAAAA_AAAA;
        tick();
        data_async = 32'hBBBB_BBBB;
        tick();
        data_async = 32'h1234_5678;
        req_async  = 1'b1;
        exp_q.push_back(32'h1234_5678);
        wait_ack(1'b1, 20, "s5_ack_rise");
        data_async = 32'hCAFE_F00D;
        tick();
        tick();
        tick();
        check("s5_no_write_acked", fifo_level, 3'd1);
        check("s5_head", m_data, 32'h1234_5678);
        req_async = 1'b0;
        wait_ack(1'b0, 20, "s5_ack_fall");
        check("s5_level_after", fifo_level, 3'd1);
        drain("s5_drain");
        check("s5_valid_low", m_valid, 1'b0);
        check("s5_data_hold", m_data, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
